// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL mode reconfiguration sequencer.
// Holds the FSM state encoding, the reconfig IP register map, and the default
// fractional-K words for the two video standards.
package pll_cfg_pkg;

  // The ST_ prefix keeps the settle state clear of the SETTLE cycle-count parameter.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MODE,
    ST_W_FRAC,
    ST_W_START,
    ST_SETTLE,
    ST_WAIT_IP,
    ST_WAIT_LOCK
  } state_t;

  localparam logic [5:0]  REG_MODE  = 6'd0;
  localparam logic [5:0]  REG_FRAC  = 6'd7;
  localparam logic [5:0]  REG_START = 6'd2;

  localparam logic [31:0] FRAC_PAL_DEF  = 32'h1544_8515;  // 28.384615 MHz x2
  localparam logic [31:0] FRAC_NTSC_DEF = 32'h29E2_B79B;  // 28.636299 MHz x2

endpackage

// File: rtl/cdc_sync2.sv
// Two-flop bit synchronizer into the CLK_50M domain.
// Ports:
//   CLK_50M  in  destination clock
//   reset    in  synchronous, active-high; clears both flops
//   d        in  asynchronous input bit
//   q        out synchronized bit, two cycles of latency
module cdc_sync2 (
  input  logic CLK_50M,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_mode_cfg_seq.sv
// PLL mode reconfiguration sequencer.
// On a PAL/NTSC change (or once after reset) it writes MODE, FRAC and START to the
// PLL reconfig IP over Avalon-MM, lets the IP settle, waits for it to finish, then
// waits for lock (with timeout). The core clock enable is held off meanwhile.
// Ports:
//   CLK_50M, reset            clock, synchronous active-high reset
//   pal, pll_locked           asynchronous inputs, synchronized internally
//   mgmt_waitrequest          reconfig IP stall
//   mgmt_write/address/writedata  Avalon-MM write master
//   cur_mode                  mode last applied (1=PAL), updated at done
//   busy                      sequence in progress
//   clk_hold                  force core clk_en low
//   done                      one-cycle pulse when a sequence ends
//   lock_err                  sticky lock timeout flag
module pll_mode_cfg_seq
  import pll_cfg_pkg::*;
#(
  parameter logic [31:0] FRAC_PAL      = FRAC_PAL_DEF,
  parameter logic [31:0] FRAC_NTSC     = FRAC_NTSC_DEF,
  parameter int unsigned SETTLE        = 4,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic        CLK_50M,
  input  logic        reset,
  input  logic        pal,
  input  logic        pll_locked,
  input  logic        mgmt_waitrequest,
  output logic        mgmt_write,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        cur_mode,
  output logic        busy,
  output logic        clk_hold,
  output logic        done,
  output logic        lock_err
);

  localparam logic [19:0] SETTLE_LAST = 20'(SETTLE - 1);
  localparam logic [19:0] LOCK_LAST   = 20'(LOCK_TIMEOUT - 1);

  logic pal_s, lock_s;

  cdc_sync2 u_sync_pal  (.CLK_50M(CLK_50M), .reset(reset), .d(pal),        .q(pal_s));
  cdc_sync2 u_sync_lock (.CLK_50M(CLK_50M), .reset(reset), .d(pll_locked), .q(lock_s));

  state_t      state, state_nx;
  logic        tgt, tgt_nx;
  logic        pending, pending_nx;
  logic [19:0] cnt, cnt_nx;
  logic        cur_mode_nx, busy_nx, clk_hold_nx, done_nx, lock_err_nx;

  always_ff @(posedge CLK_50M) begin
    if (reset) begin
      state    <= ST_IDLE;
      tgt      <= 1'b0;
      pending  <= INIT_ON_RESET;
      cnt      <= '0;
      cur_mode <= 1'b0;
      busy     <= 1'b0;
      clk_hold <= INIT_ON_RESET;
      done     <= 1'b0;
      lock_err <= 1'b0;
    end else begin
      state    <= state_nx;
      tgt      <= tgt_nx;
      pending  <= pending_nx;
      cnt      <= cnt_nx;
      cur_mode <= cur_mode_nx;
      busy     <= busy_nx;
      clk_hold <= clk_hold_nx;
      done     <= done_nx;
      lock_err <= lock_err_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    tgt_nx         = tgt;
    pending_nx     = pending;
    cnt_nx         = cnt;
    cur_mode_nx    = cur_mode;
    busy_nx        = busy;
    clk_hold_nx    = clk_hold;
    done_nx        = 1'b0;
    lock_err_nx    = lock_err;
    mgmt_write     = 1'b0;
    mgmt_address   = '0;
    mgmt_writedata = '0;

    case (state)
      ST_IDLE: begin
        // Target is latched here so a pal change mid-sequence cannot tear the writes;
        // it is picked up by the next pass through IDLE instead.
        if (pending || (pal_s != cur_mode)) begin
          tgt_nx      = pal_s;
          busy_nx     = 1'b1;
          clk_hold_nx = 1'b1;
          state_nx    = ST_W_MODE;
        end
      end
      ST_W_MODE: begin
        mgmt_write   = 1'b1;
        mgmt_address = REG_MODE;
        if (!mgmt_waitrequest) state_nx = ST_W_FRAC;
      end
      ST_W_FRAC: begin
        mgmt_write     = 1'b1;
        mgmt_address   = REG_FRAC;
        mgmt_writedata = tgt ? FRAC_PAL : FRAC_NTSC;
        if (!mgmt_waitrequest) state_nx = ST_W_START;
      end
      ST_W_START: begin
        mgmt_write   = 1'b1;
        mgmt_address = REG_START;
        if (!mgmt_waitrequest) begin
          state_nx = ST_SETTLE;
          cnt_nx   = '0;
        end
      end
      ST_SETTLE: begin
        // The IP needs a few cycles before waitrequest reflects the reconfig in progress.
        if (cnt == SETTLE_LAST) begin
          cnt_nx   = '0;
          state_nx = ST_WAIT_IP;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      ST_WAIT_IP: begin
        if (!mgmt_waitrequest) begin
          cnt_nx   = '0;
          state_nx = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        // A timeout still finishes the sequence so the core is never held forever.
        if (lock_s || (cnt == LOCK_LAST)) begin
          if (!lock_s) lock_err_nx = 1'b1;
          state_nx    = ST_IDLE;
          done_nx     = 1'b1;
          cur_mode_nx = tgt;
          busy_nx     = 1'b0;
          clk_hold_nx = 1'b0;
          pending_nx  = 1'b0;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pll_mode_cfg_seq.sv
// Directed bench for pll_mode_cfg_seq (SETTLE=4, LOCK_TIMEOUT=40).
module tb_pll_mode_cfg_seq;

  localparam logic [31:0] PAL_W  = 32'h1544_8515;
  localparam logic [31:0] NTSC_W = 32'h29E2_B79B;

  logic        CLK_50M = 1'b0;
  logic        reset, pal, pll_locked, mgmt_waitrequest;
  logic        mgmt_write, cur_mode, busy, clk_hold, done, lock_err;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [38:0] wq[$];  // {valid, address, data} of every accepted write

  always #10 CLK_50M = ~CLK_50M;

  pll_mode_cfg_seq #(.SETTLE(4), .LOCK_TIMEOUT(40)) dut (
    .CLK_50M(CLK_50M), .reset(reset), .pal(pal), .pll_locked(pll_locked),
    .mgmt_waitrequest(mgmt_waitrequest), .mgmt_write(mgmt_write),
    .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
    .cur_mode(cur_mode), .busy(busy), .clk_hold(clk_hold), .done(done),
    .lock_err(lock_err));

  // Inputs only change just after posedge, so the negedge view is what the next edge sees.
  always @(negedge CLK_50M) begin
    if (!reset) begin
      if (mgmt_write && !mgmt_waitrequest) wq.push_back({1'b1, mgmt_address, mgmt_writedata});
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK_50M);
    #1;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [5:0] a, input logic [31:0] d);
    logic [38:0] e;
    e = (idx < wq.size()) ? wq[idx] : 39'd0;
    chk(tag, 64'(e), 64'({1'b1, a, d}));
  endtask

  initial begin
    int wb, db, ok;
    reset = 1'b1; pal = 1'b0; pll_locked = 1'b0; mgmt_waitrequest = 1'b0;
    step(3);
    chk("rst_write", 64'(mgmt_write), 64'd0);
    chk("rst_addr",  64'(mgmt_address), 64'd0);
    chk("rst_data",  64'(mgmt_writedata), 64'd0);
    chk("rst_state", 64'({cur_mode, busy, clk_hold, done, lock_err}), 64'b00100);

    // 1: init sequence after reset, lock arrives 20 cycles after release
    reset = 1'b0;
    step(2);
    chk("t1_busy_hold", 64'({busy, clk_hold}), 64'b11);
    step(18);
    pll_locked = 1'b1;
    wait_done("t1_done_to", 1, 60);
    step(3);
    chk("t1_nwr", 64'(wq.size()), 64'd3);
    chk_wr("t1_wr0", 0, 6'd0, 32'd0);
    chk_wr("t1_wr1", 1, 6'd7, NTSC_W);
    chk_wr("t1_wr2", 2, 6'd2, 32'd0);
    chk("t1_dones", 64'(done_cnt), 64'd1);
    chk("t1_state", 64'({cur_mode, busy, clk_hold, lock_err}), 64'b0000);

    // 2: PAL request in IDLE; cur_mode must stay 0 and busy high until done
    wb = wq.size(); db = done_cnt; ok = 1;
    pal = 1'b1;
    step(3);
    for (int i = 0; i < 40 && done_cnt == db; i++) begin
      if (!done && (busy !== 1'b1 || cur_mode !== 1'b0 || clk_hold !== 1'b1)) ok = 0;
      step(1);
    end
    chk("t2_busy_thru", 64'(ok), 64'd1);
    wait_done("t2_done_to", db + 1, 5);
    chk("t2_cur_mode", 64'(cur_mode), 64'd1);
    chk("t2_nwr", 64'(wq.size() - wb), 64'd3);
    chk_wr("t2_wr0", wb,     6'd0, 32'd0);
    chk_wr("t2_wr1", wb + 1, 6'd7, PAL_W);
    chk_wr("t2_wr2", wb + 2, 6'd2, 32'd0);

    // 3: waitrequest stalls the FRAC write for 10 edges
    step(2);
    wb = wq.size(); db = done_cnt; ok = 0;
    pal = 1'b0;
    step(4);
    mgmt_waitrequest = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (mgmt_write === 1'b1 && mgmt_address === 6'd7 && mgmt_writedata === NTSC_W) ok++;
      if (i < 10) step(1);
    end
    chk("t3_stable", 64'(ok), 64'd11);
    mgmt_waitrequest = 1'b0;
    step(1);
    chk("t3_start_addr", 64'({mgmt_write, mgmt_address}), 64'({1'b1, 6'd2}));
    wait_done("t3_done_to", db + 1, 40);
    chk("t3_nwr", 64'(wq.size() - wb), 64'd3);
    chk_wr("t3_wr1", wb + 1, 6'd7, NTSC_W);
    chk("t3_cur_mode", 64'(cur_mode), 64'd0);

    // 4a: pal flips back while FRAC is in flight -> PAL sequence then NTSC sequence
    step(2);
    wb = wq.size(); db = done_cnt;
    pal = 1'b1;
    step(4);
    pal = 1'b0;
    wait_done("t4_done_to", db + 2, 80);
    step(3);
    chk("t4_nwr", 64'(wq.size() - wb), 64'd6);
    chk_wr("t4_wr1", wb + 1, 6'd7, PAL_W);
    chk_wr("t4_wr4", wb + 4, 6'd7, NTSC_W);
    chk("t4_cur_mode", 64'(cur_mode), 64'd0);

    // 4b: sub-cycle pal pulse in IDLE never reaches the synchronizer output
    wb = wq.size(); db = done_cnt;
    pal = 1'b1;
    #3 pal = 1'b0;
    step(20);
    chk("t4b_nwr", 64'(wq.size() - wb), 64'd0);
    chk("t4b_quiet", 64'({busy, cur_mode, 8'(done_cnt - db)}), 64'd0);

    // 5: lock never comes -> timeout 40 cycles into WAIT_LOCK (done after edge 51)
    pll_locked = 1'b0;
    step(3);
    db = done_cnt;
    pal = 1'b1;
    step(50);
    chk("t5_pre", 64'({done, lock_err, busy}), 64'b001);
    step(1);
    chk("t5_done", 64'({done, lock_err}), 64'b11);
    chk("t5_release", 64'({busy, clk_hold, cur_mode}), 64'b001);
    step(3);
    chk("t5_sticky", 64'(lock_err), 64'd1);

    // 6: reset while in W_START drops the write; init sequence reruns after release
    pll_locked = 1'b1;
    step(3);
    pal = 1'b0;
    step(5);
    chk("t6_in_start", 64'({mgmt_write, mgmt_address}), 64'({1'b1, 6'd2}));
    wb = wq.size();
    reset = 1'b1;
    step(1);
    chk("t6_rst_out", 64'({mgmt_write, busy, clk_hold, lock_err, cur_mode}), 64'b00100);
    chk("t6_dropped", 64'(wq.size() - wb), 64'd0);
    step(1);
    db = done_cnt;
    reset = 1'b0;
    wait_done("t6_done_to", db + 1, 60);
    chk("t6_nwr", 64'(wq.size() - wb), 64'd3);
    chk_wr("t6_wr1", wb + 1, 6'd7, NTSC_W);
    chk("t6_state", 64'({cur_mode, clk_hold, lock_err}), 64'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
